// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that serializes one requester's word at a time, LSB first, into a
// shared sequence detector and reports the number of detector hits seen for that word.
module seq_det_scheduler #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 5,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data_in,
  output logic [N_REQ-1:0]        grant,
  output logic                    det_clr,
  output logic                    ser_bit,
  output logic                    ser_valid,
  input  logic                    det_hit,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic [CNT_W-1:0]        hit_count
);

  localparam int unsigned BitCntW = $clog2(WORD_W);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StDrain, StReport} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    win_id_q, win_id_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;

  logic               found;
  logic [ID_W-1:0]    win_sel;
  logic [WORD_W-1:0]  sel_word;
  logic               hit_ok;
  logic [CNT_W-1:0]   cnt_inc;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    found   = 1'b0;
    win_sel = rr_ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((32'(rr_ptr_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = idx;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win_sel) sel_word = data_in[i*WORD_W +: WORD_W];
    end
  end

  // det_hit reflects the previous cycle's bit, so it only counts after a SHIFT cycle.
  assign hit_ok  = ((state_q == StShift) && (bit_cnt_q != '0)) || (state_q == StDrain);
  assign cnt_inc = (hit_ok && det_hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_id_d    = win_id_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    hit_count_d = hit_count_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          win_id_d  = win_sel;
          shreg_d   = sel_word;
          bit_cnt_d = '0;
          cnt_d     = '0;
          state_d   = StLoad;
        end
      end
      StLoad: state_d = StShift;
      StShift: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_inc;
        if (bit_cnt_q == BitCntW'(WORD_W - 1)) begin
          state_d = StDrain;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        cnt_d       = cnt_inc;
        done_id_d   = win_id_q;
        hit_count_d = cnt_inc;
        rr_ptr_d    = (win_id_q == ID_W'(N_REQ - 1)) ? '0 : win_id_q + 1'b1;
        state_d     = StReport;
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_id_q    <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_id_q    <= win_id_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      hit_count_q <= hit_count_d;
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if ((state_q == StLoad) && (ID_W'(i) == win_id_q)) grant[i] = 1'b1;
    end
  end

  assign det_clr   = (state_q == StLoad);
  assign ser_valid = (state_q == StShift);
  assign ser_bit   = ser_valid & shreg_q[0];
  assign done      = (state_q == StReport);
  assign done_id   = done_id_q;
  assign hit_count = hit_count_q;

endmodule
